// File: rtl/pll_clock_divider.sv
// Integer clock divider behind the PLL/DCO: divided clock, period-start tick, CDC-qualified ratio.
// Latency: outputs registered; enable seen in IDLE gives div_clk=1/tick=1 after that same edge; ratio applies at a period boundary.
// No backpressure: free-running; ratio changes wait in a shadow register until the current period ends.
module pll_clock_divider #(
  parameter int WIDTH         = 3,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] ratio,
  output logic             div_clk,
  output logic             tick,
  output logic             pending,
  output logic [WIDTH-1:0] active_ratio
);

  localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] MIN_RATIO = WIDTH'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] r1_q, r2_q, r3_q;

  logic             cand_qual;
  logic [WIDTH-1:0] cand;
  logic             last_cyc;
  logic             apply;
  logic [WIDTH:0]   half_n;

  // Resynchronise the quasi-static ratio from the housekeeping domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r1_q <= DEF_RATIO;
      r2_q <= DEF_RATIO;
      r3_q <= DEF_RATIO;
    end else begin
      r1_q <= ratio;
      r2_q <= r1_q;
      r3_q <= r2_q;
    end
  end

  // Next-state: period counter, boundary ratio swap, registered div_clk/tick, shadow qualification.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    active_d  = active_q;
    apply     = 1'b0;
    div_clk_d = 1'b0;
    tick_d    = 1'b0;
    half_n    = '0;
    pending_d = pending_q;
    shadow_d  = shadow_q;

    // Only trust r3 once the stage ahead of it agrees; 0/1 are not legal ratios.
    cand_qual = (r2_q == r3_q);
    cand      = (r3_q < MIN_RATIO) ? MIN_RATIO : r3_q;
    last_cyc  = (count_q == (active_q - WIDTH'(1)));

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable) begin
          state_d = RUN;
          apply   = pending_q;
        end
      end
      RUN: begin
        if (last_cyc) begin
          // Low phase is already done here, so leaving for IDLE cannot cut a high pulse.
          count_d = '0;
          apply   = pending_q;
          if (!enable) begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    if (apply) begin
      active_d = shadow_q;
    end

    // High for ceil(N/2) counts; outputs are computed for the cycle being entered.
    half_n = ({1'b0, active_d} + (WIDTH+1)'(1)) >> 1;
    if (state_d == RUN) begin
      div_clk_d = ({1'b0, count_d} < half_n);
      tick_d    = (count_d == '0);
    end

    // Compare against the ratio that will be in force, so a swap this cycle is not re-requested.
    if (apply) begin
      pending_d = 1'b0;
    end
    if (cand_qual) begin
      if (cand != active_d) begin
        pending_d = 1'b1;
        shadow_d  = cand;
      end else begin
        pending_d = 1'b0;
      end
    end
  end

  // State and output registers; reset abandons any partial period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      div_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      active_q  <= DEF_RATIO;
      shadow_q  <= DEF_RATIO;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
    end
  end

  assign div_clk      = div_clk_q;
  assign tick         = tick_q;
  assign pending      = pending_q;
  assign active_ratio = active_q;

endmodule

// File: tb/tb_pll_clock_divider.sv
// Directed bench for pll_clock_divider: vector table plus hand-written corner sequences.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Every wait on the DUT is bounded; a global time limit ends the run.
module tb_pll_clock_divider;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [2:0] ratio;
  logic       div_clk;
  logic       tick;
  logic       pending;
  logic [2:0] active_ratio;

  int errors = 0;
  int checks = 0;

  int cyc       = 0;
  int last_tick = -1;
  int min_gap   = 1000;
  int max_gap   = 0;
  int runt_err  = 0;

  pll_clock_divider #(.WIDTH(3), .DEFAULT_RATIO(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .ratio        (ratio),
    .div_clk      (div_clk),
    .tick         (tick),
    .pending      (pending),
    .active_ratio (active_ratio)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] rat;
    logic       e_div;
    logic       e_tick;
    logic       e_pend;
    logic [2:0] e_act;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_stats();
    last_tick = -1;
    min_gap   = 1000;
    max_gap   = 0;
  endtask

  // One clock; tracks tick spacing and any ratio change not aligned to a tick.
  task automatic step();
    logic [2:0] prev_act;
    logic       prev_rst;
    int         gap;
    prev_act = active_ratio;
    prev_rst = reset;
    @(posedge clock);
    #1;
    cyc++;
    if (tick) begin
      if (last_tick >= 0) begin
        gap = cyc - last_tick;
        if (gap < min_gap) min_gap = gap;
        if (gap > max_gap) max_gap = gap;
      end
      last_tick = cyc;
    end
    if (!prev_rst && (active_ratio != prev_act) && !tick) runt_err++;
  endtask

  task automatic wait_active(input logic [2:0] want, input int limit, input string name);
    int n;
    n = 0;
    while (active_ratio != want && n < limit) begin
      step();
      n++;
    end
    check(name, int'(active_ratio), int'(want));
  endtask

  task automatic wait_tick(input int limit, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < limit);
    check(name, int'(tick), 1);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    ratio  = 3'd2;

    // rst, en, ratio, div_clk, tick, pending, active_ratio
    vecs.push_back({1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd2});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 3'd3});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd4});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd4});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd4});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd4});
    vecs.push_back({1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 3'd4});

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      ratio  = vecs[i].rat;
      step();
      check($sformatf("vec%0d div_clk", i), int'(div_clk), int'(vecs[i].e_div));
      check($sformatf("vec%0d tick", i), int'(tick), int'(vecs[i].e_tick));
      check($sformatf("vec%0d pending", i), int'(pending), int'(vecs[i].e_pend));
      check($sformatf("vec%0d active_ratio", i), int'(active_ratio), int'(vecs[i].e_act));
    end

    // Illegal ratios 1 and 0 both clamp to 2.
    reset_stats();
    ratio = 3'd1;
    for (int i = 0; i < 12; i++) step();
    check("clamp1 active_ratio", int'(active_ratio), 2);
    check("clamp1 pending", int'(pending), 0);
    wait_tick(8, "clamp1 tick seen");
    check("clamp1 div_clk at tick", int'(div_clk), 1);
    step();
    check("clamp1 div_clk low", int'(div_clk), 0);
    check("clamp1 no tick", int'(tick), 0);
    step();
    check("clamp1 next tick", int'(tick), 1);
    ratio = 3'd0;
    for (int i = 0; i < 8; i++) step();
    check("clamp0 active_ratio", int'(active_ratio), 2);
    check("clamp0 pending", int'(pending), 0);
    check("clamp min period", min_gap, 2);

    // Glitching ratio never qualifies; settling at 6 applies on a boundary.
    ratio = 3'd5;
    wait_active(3'd5, 30, "glitch start active 5");
    reset_stats();
    for (int i = 0; i < 10; i++) begin
      ratio = (i % 2 == 0) ? 3'd6 : 3'd5;
      step();
      check($sformatf("glitch%0d pending", i), int'(pending), 0);
      check($sformatf("glitch%0d active_ratio", i), int'(active_ratio), 5);
    end
    ratio = 3'd6;
    wait_active(3'd6, 30, "glitch settled active 6");
    for (int i = 0; i < 14; i++) step();
    check("glitch min period", min_gap, 5);
    check("glitch max period", max_gap, 6);

    // N=7: drop enable at count=1; the period completes 4 high / 3 low, then IDLE.
    ratio = 3'd7;
    wait_active(3'd7, 30, "n7 active 7");
    wait_tick(20, "n7 tick seen");
    step();
    check("n7 count1 div_clk", int'(div_clk), 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("n7 count%0d div_clk", i + 2), int'(div_clk), (i < 2) ? 1 : 0);
      check($sformatf("n7 count%0d tick", i + 2), int'(tick), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("n7 idle%0d div_clk", i), int'(div_clk), 0);
      check($sformatf("n7 idle%0d tick", i), int'(tick), 0);
    end
    enable = 1'b1;
    step();
    check("n7 reenable div_clk", int'(div_clk), 1);
    check("n7 reenable tick", int'(tick), 1);
    check("n7 reenable active_ratio", int'(active_ratio), 7);
    step();
    check("n7 reenable count1 div_clk", int'(div_clk), 1);
    check("n7 reenable count1 tick", int'(tick), 0);

    // N=6: reset at count=2 abandons the period; pending shadow loads on entry to RUN.
    ratio = 3'd6;
    wait_active(3'd6, 30, "n6 active 6");
    step();
    step();
    check("n6 count2 div_clk", int'(div_clk), 1);
    reset = 1'b1;
    step();
    check("n6 reset div_clk", int'(div_clk), 0);
    check("n6 reset tick", int'(tick), 0);
    check("n6 reset pending", int'(pending), 0);
    check("n6 reset active_ratio", int'(active_ratio), 2);
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("idle pending after reset", int'(pending), 1);
    check("idle active_ratio after reset", int'(active_ratio), 2);
    check("idle div_clk after reset", int'(div_clk), 0);
    enable = 1'b1;
    step();
    check("entry div_clk", int'(div_clk), 1);
    check("entry tick", int'(tick), 1);
    check("entry active_ratio", int'(active_ratio), 6);
    check("entry pending", int'(pending), 0);

    check("no ratio change off boundary", runt_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
